// File: rtl/vend_param_fsm.sv
// Moore vending controller for one product line: coin credit, vend, change/refund,
// stock tracking with sold-out lockout and refill.
module vend_param_fsm #(
   parameter int unsigned PRICE      = 3,
   parameter int unsigned CREDIT_W   = 4,
   parameter int unsigned STOCK_INIT = 4,
   parameter int unsigned STOCK_W    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rs5,
   input  logic                rs10,
   input  logic                cancel,
   input  logic                refill,
   output logic                item1,
   output logic                rs5out,
   output logic [CREDIT_W-1:0] credit,
   output logic [STOCK_W-1:0]  stock,
   output logic                sold_out,
   output logic                busy
);

   typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, SOLDOUT} state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [STOCK_W-1:0]  ONE_S   = STOCK_W'(1);

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_n, coin, sum, remain;
   logic [STOCK_W-1:0]  stock_n, stock_dec;

   // {rs10, rs5} is already 2*rs10 + rs5
   assign coin      = CREDIT_W'({rs10, rs5});
   assign sum       = credit + coin;
   assign remain    = credit - PRICE_C;
   assign stock_dec = stock - ONE_S;

   // Strobes are registered from the next state so they never glitch on decode
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         credit   <= '0;
         stock    <= STOCK_C;
         item1    <= 1'b0;
         rs5out   <= 1'b0;
         sold_out <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         credit   <= credit_n;
         stock    <= stock_n;
         item1    <= (state_n == VEND);
         rs5out   <= (state_n == CHANGE);
         sold_out <= (state_n == SOLDOUT);
         busy     <= (state_n == VEND) || (state_n == CHANGE);
      end
   end

   always_comb begin
      state_n  = state;
      credit_n = credit;
      stock_n  = stock;
      case (state)
         IDLE, COLLECT: begin
            if (state == IDLE && refill) stock_n = STOCK_C;
            if (state == COLLECT && cancel) begin
               credit_n = sum;
               state_n  = CHANGE;
            end else if (coin != '0) begin
               credit_n = sum;
               state_n  = (sum >= PRICE_C) ? VEND : COLLECT;
            end
         end
         VEND: begin
            credit_n = remain;
            stock_n  = stock_dec;
            if (remain != '0)          state_n = CHANGE;
            else if (stock_dec == '0)  state_n = SOLDOUT;
            else                       state_n = IDLE;
         end
         CHANGE: begin
            credit_n = credit - ONE_C;
            if (credit == ONE_C) state_n = (stock == '0) ? SOLDOUT : IDLE;
         end
         SOLDOUT: begin
            if (refill) begin
               stock_n = STOCK_C;
               state_n = IDLE;
            end
            // a coin offered while locked out (even alongside refill) is handed back
            if (coin != '0) begin
               credit_n = coin;
               state_n  = CHANGE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vend_param_fsm.sv
// Self-checking bench for vend_param_fsm: directed scenarios plus random traffic
// against a transaction-level model that schedules whole vend/refund sequences.
module tb_vend_param_fsm;

   localparam int PRICE      = 3;
   localparam int STOCK_INIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, rs5, rs10, cancel, refill;
   logic       item1, rs5out, sold_out, busy;
   logic [3:0] credit;
   logic [2:0] stock;

   logic       b_rs5, b_rs10, b_cancel, b_refill;
   logic       b_item1, b_rs5out, b_sold_out, b_busy;
   logic [3:0] b_credit;
   logic [2:0] b_stock;

   vend_param_fsm #(.PRICE(PRICE), .CREDIT_W(4), .STOCK_INIT(STOCK_INIT), .STOCK_W(3)) dut (
      .clk(clk), .reset(reset), .rs5(rs5), .rs10(rs10), .cancel(cancel), .refill(refill),
      .item1(item1), .rs5out(rs5out), .credit(credit), .stock(stock),
      .sold_out(sold_out), .busy(busy));

   vend_param_fsm #(.PRICE(3), .CREDIT_W(4), .STOCK_INIT(1), .STOCK_W(3)) dut1 (
      .clk(clk), .reset(reset), .rs5(b_rs5), .rs10(b_rs10), .cancel(b_cancel), .refill(b_refill),
      .item1(b_item1), .rs5out(b_rs5out), .credit(b_credit), .stock(b_stock),
      .sold_out(b_sold_out), .busy(b_busy));

   typedef struct {
      bit item1;
      bit rs5out;
      bit sold_out;
      bit busy;
      int credit;
      int stock;
   } disp_t;

   disp_t q[$];
   disp_t exp_d;
   int    m_stock;
   int    checks = 0;
   int    failures = 0;
   int    n_item = 0, n_rs5 = 0, b_item = 0, b_rs = 0;

   task automatic check(input string tag, input logic [31:0] obs, input int expv);
      checks++;
      assert (obs === 32'(expv)) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic disp_t mk(bit it, bit r5, int cr, int st, bit so);
      disp_t d;
      d.item1 = it; d.rs5out = r5; d.busy = it | r5;
      d.credit = cr; d.stock = st; d.sold_out = so;
      return d;
   endfunction

   task automatic schedule_refund(input int n, input int st);
      for (int i = n; i >= 1; i--) q.push_back(mk(0, 1, i, st, 0));
      q.push_back(mk(0, 0, 0, st, st == 0));
   endtask

   task automatic model_reset();
      q.delete();
      m_stock = STOCK_INIT;
      exp_d   = mk(0, 0, 0, STOCK_INIT, 0);
   endtask

   // One clock edge of the model; a scheduled sequence ignores all inputs
   task automatic model_edge(input bit c5, input bit c10, input bit cc, input bit rf);
      int coin, cr, rem;
      coin = int'(c5) + 2 * int'(c10);
      if (q.size() > 0) begin
         exp_d = q.pop_front();
         return;
      end
      if (exp_d.sold_out) begin
         if (rf) m_stock = STOCK_INIT;
         if (coin > 0) begin
            schedule_refund(coin, m_stock);
            exp_d = q.pop_front();
         end else exp_d = mk(0, 0, 0, m_stock, !rf);
      end else begin
         cr = exp_d.credit;
         if (rf && cr == 0) m_stock = STOCK_INIT;
         if (cc && cr > 0) begin
            schedule_refund(cr + coin, m_stock);
            exp_d = q.pop_front();
         end else if (coin > 0) begin
            cr += coin;
            if (cr >= PRICE) begin
               q.push_back(mk(1, 0, cr, m_stock, 0));
               m_stock--;
               rem = cr - PRICE;
               if (rem > 0) schedule_refund(rem, m_stock);
               else q.push_back(mk(0, 0, 0, m_stock, m_stock == 0));
               exp_d = q.pop_front();
            end else exp_d = mk(0, 0, cr, m_stock, 0);
         end else exp_d = mk(0, 0, cr, m_stock, 0);
      end
   endtask

   task automatic compare_all();
      check("item1", item1, exp_d.item1);
      check("rs5out", rs5out, exp_d.rs5out);
      check("credit", credit, exp_d.credit);
      check("stock", stock, exp_d.stock);
      check("sold_out", sold_out, exp_d.sold_out);
      check("busy", busy, exp_d.busy);
   endtask

   task automatic step(input bit c5, input bit c10, input bit cc, input bit rf);
      @(negedge clk);
      rs5 = c5; rs10 = c10; cancel = cc; refill = rf;
      @(posedge clk);
      model_edge(c5, c10, cc, rf);
      #1;
      compare_all();
      n_item += int'(item1);
      n_rs5  += int'(rs5out);
   endtask

   task automatic step1(input bit c5, input bit c10, input bit cc, input bit rf);
      @(negedge clk);
      b_rs5 = c5; b_rs10 = c10; b_cancel = cc; b_refill = rf;
      @(posedge clk);
      #1;
      b_item += int'(b_item1);
      b_rs   += int'(b_rs5out);
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (q.size() == 0 && exp_d.credit == 0) break;
         if (q.size() == 0) step(0, 0, 1, 0);
         else step(0, 0, 0, 0);
      end
      check("drain_busy", busy, 0);
      check("drain_credit", credit, 0);
   endtask

   initial begin
      reset = 1'b0;
      rs5 = 0; rs10 = 0; cancel = 0; refill = 0;
      b_rs5 = 0; b_rs10 = 0; b_cancel = 0; b_refill = 0;
      model_reset();
      #12;
      compare_all();
      check("b_stock_reset", b_stock, 1);
      @(negedge clk);
      reset = 1'b1;

      // two 10-unit coins, with further coins offered while busy
      n_item = 0; n_rs5 = 0;
      step(0, 1, 0, 0);
      check("s1_credit2", credit, 2);
      step(0, 1, 0, 0);
      check("s1_credit4", credit, 4);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check("s1_items", n_item, 1);
      check("s1_pulses", n_rs5, 1);
      check("s1_credit_end", credit, 0);
      check("s1_stock", stock, 3);

      // both coins in one cycle: exact price
      n_item = 0; n_rs5 = 0;
      step(1, 1, 0, 0);
      check("s2_credit3", credit, 3);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("s2_items", n_item, 1);
      check("s2_pulses", n_rs5, 0);
      check("s2_stock", stock, 2);

      // cancel with a same-cycle coin refunds both
      n_item = 0; n_rs5 = 0;
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("s3_items", n_item, 0);
      check("s3_pulses", n_rs5, 2);
      check("s3_credit", credit, 0);

      // single-stock instance: sell out, coin bounce, refill
      rs5 = 0; rs10 = 0; cancel = 0; refill = 0;
      b_item = 0; b_rs = 0;
      step1(1, 0, 0, 0); step1(1, 0, 0, 0); step1(1, 0, 0, 0); step1(0, 0, 0, 0);
      check("s4_vend_items", b_item, 1);
      check("s4_sold_out", b_sold_out, 1);
      check("s4_stock0", b_stock, 0);
      b_item = 0; b_rs = 0;
      step1(0, 1, 0, 0); step1(0, 0, 0, 0); step1(0, 0, 0, 0); step1(0, 0, 0, 0);
      check("s4_bounce_pulses", b_rs, 2);
      check("s4_bounce_items", b_item, 0);
      check("s4_still_sold_out", b_sold_out, 1);
      step1(0, 0, 0, 1);
      step1(0, 0, 0, 0);
      check("s4_refill_sold_out", b_sold_out, 0);
      check("s4_refill_stock", b_stock, 1);
      // the DUT idled through those cycles; realign the model by stepping it idle
      step(0, 0, 0, 0);

      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end

      // asynchronous reset in the middle of a change sequence
      drain();
      step(0, 0, 0, 1);
      check("s6_refilled", stock, STOCK_INIT);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check("s6_in_change", rs5out, 1);
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      check("s6_rs5out_async", rs5out, 0);
      check("s6_credit", credit, 0);
      check("s6_stock", stock, STOCK_INIT);
      check("s6_busy", busy, 0);
      check("s6_item1", item1, 0);
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("s6_idle_after", credit, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_param_fsm.md
Name: vend_param_fsm

Overview:
Parametrised Moore vending controller for one product line. It accepts 5- and 10-unit coins, accumulates credit, and vends when credit reaches PRICE. Overpayment is returned as one rs5out pulse per 5-unit coin. Adds cancel/refund, stock tracking, a sold-out lockout with coin return, and refill. All outputs are decoded from registered state and are glitch-free.

Parameters:
PRICE, 3, item price in 5-unit coins (3 = 15); range 1 .. 2^CREDIT_W-3
CREDIT_W, 4, credit register width; must satisfy PRICE+2 <= 2^CREDIT_W-1
STOCK_INIT, 4, stock loaded at reset and on refill; 1 .. 2^STOCK_W-1
STOCK_W, 3, stock counter width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
rs5  input  1  5-unit coin present this cycle (value 1)
rs10  input  1  10-unit coin present this cycle (value 2)
cancel  input  1  refund the accumulated credit
refill  input  1  reload stock to STOCK_INIT
item1  output  1  dispense strobe; high for exactly one cycle per sale
rs5out  output  1  change/refund strobe; one cycle per 5 units returned
credit  output  CREDIT_W  current credit in 5-unit coins
stock  output  STOCK_W  items remaining
sold_out  output  1  high while state is SOLDOUT
busy  output  1  high in VEND or CHANGE; coins are ignored while high

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, credit=0, stock=STOCK_INIT, item1=rs5out=sold_out=busy=0. Applies mid-operation; pending change is discarded.
- Coin value each cycle: coin = rs5 + 2*rs10. If both are high, value is 3 and both coins are accepted.
- States are IDLE, COLLECT, VEND, CHANGE, SOLDOUT. Moore outputs:
  - item1 = (VEND)
  - rs5out = (CHANGE)
  - busy = (VEND | CHANGE)
  - sold_out = (SOLDOUT)
- IDLE/COLLECT, coin>0, cancel=0: credit_n = credit + coin.
  - If credit_n >= PRICE: go to VEND.
  - Else if credit_n > 0: go to COLLECT.
  - No overflow is possible, since max credit is PRICE+2.
- COLLECT, cancel=1: credit_n = credit + coin (a same-cycle coin is still accepted), go to CHANGE, refund all. cancel in IDLE with credit=0 and coin=0 is ignored.
- VEND (exactly one cycle):
  - At the exit edge: credit -= PRICE, stock -= 1.
  - Remainder > 0: go to CHANGE.
  - Remainder = 0: go to SOLDOUT if the new stock = 0, else IDLE.
- CHANGE:
  - rs5out=1 every cycle; credit decrements by 1 at each edge.
  - Exit when credit becomes 0: to SOLDOUT if stock=0, else IDLE.
  - Number of rs5out cycles = credit on entry, exactly.
- VEND/CHANGE: rs5, rs10, cancel, and refill are ignored; coins are rejected and not credited.
- SOLDOUT, coin>0: credit = coin, go to CHANGE. The coin is returned immediately; no item.
- refill: accepted only in IDLE or SOLDOUT. stock = STOCK_INIT. SOLDOUT goes to IDLE. refill takes priority over a coin in the same cycle in SOLDOUT; that coin is refunded.
- Latency:
  - A coin sampled at edge k appears on credit after edge k.
  - If it completes PRICE, item1 is high for the cycle after edge k.
  - The first rs5out follows at the next edge.
- credit and stock outputs are registered values; no combinational input-to-output paths.

Test Plan (PRICE=3, STOCK_INIT=4 unless noted):
1. Release reset; rs10 one cycle, then rs10 one cycle.
   Required: credit goes 2 then 4; item1 high for 1 cycle; then rs5out high for 1 cycle; credit=0, stock=3, back to IDLE.
2. rs5=rs10=1 in the same cycle.
   Required: credit=3; item1 for 1 cycle; no rs5out pulse; stock decrements.
3. rs5 one cycle, then cancel together with rs5 one cycle.
   Required: 2 rs5out pulses; no item1; credit=0.
4. STOCK_INIT=1: vend once with rs5×3.
   Required: sold_out=1.
   Then rs10: exactly 2 rs5out pulses and no item1.
   Then refill: sold_out=0, stock=1.
5. Insert rs10 while busy (during VEND and CHANGE of scenario 1).
   Required: coin ignored; credit ends at 0; no extra rs5out.
6. Assert reset=0 mid-CHANGE, asynchronous to clk.
   Required: rs5out drops to 0 immediately, before the next edge; credit=0, stock=STOCK_INIT, state=IDLE.
